acq_fifo_ctrl: RTL and testbench

Acquisition controller for the g_clk-domain capture FIFO between the clock-domain-crossing output (g_valid / g_sync2_diff) and the block-throttled pipe-out. It runs the FIFO reset/settle sequence in hardware, so the host no longer needs timed software delays. It gates writes into a bounded capture window of N samples, tracks overflow, and drives the pipe-out ready flag on whole-block availability.

---
 rtl/acq_fifo_ctrl.sv | 177 +++++++++++++++++
 tb/tb_acq_fifo_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/acq_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : acq_fifo_ctrl
// Purpose  : Capture-FIFO acquisition controller: hardware srst/settle
//            sequencing, bounded capture window, overflow tracking and
//            block-granular pipe-out ready.
// Revision : 1.0  initial release
// ============================================================================
module acq_fifo_ctrl #(
    parameter int DATASIZE      = 8,
    parameter int COUNTSIZE     = 32,
    parameter int WCNTSIZE      = 18,
    parameter int RCNTSIZE      = 16,
    parameter int FIFO_WDEPTH   = 131072,
    parameter int HEADROOM      = 128,
    parameter int RST_CYCLES    = 4,
    parameter int SETTLE_CYCLES = 30,
    parameter int BLOCK_WORDS   = 256
) (
    input  logic                 g_clk,
    input  logic                 g_rst,
    input  logic                 g_start,
    input  logic                 g_stop,
    input  logic [COUNTSIZE-1:0] g_n_samples,
    input  logic                 g_valid,
    input  logic [DATASIZE-1:0]  g_din,
    input  logic [WCNTSIZE-1:0]  g_wr_count,
    input  logic [RCNTSIZE-1:0]  g_rd_count,
    output logic                 g_fifo_srst,
    output logic                 g_fifo_wren,
    output logic [DATASIZE-1:0]  g_fifo_din,
    output logic                 g_pipe_ready,
    output logic [2:0]           g_state,
    output logic [COUNTSIZE-1:0] g_captured,
    output logic [15:0]          g_dropped,
    output logic                 g_overflow,
    output logic                 g_done
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_FLUSH   = 3'd1;
    localparam logic [2:0] S_SETTLE  = 3'd2;
    localparam logic [2:0] S_CAPTURE = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    localparam logic [WCNTSIZE:0]    C_ROOM_LIMIT = (WCNTSIZE+1)'(FIFO_WDEPTH - HEADROOM);
    localparam logic [RCNTSIZE:0]    C_BLOCK_LIM  = (RCNTSIZE+1)'(BLOCK_WORDS);
    localparam logic [15:0]          C_FLUSH_LAST = 16'(RST_CYCLES - 1);
    localparam logic [15:0]          C_SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
    localparam logic [COUNTSIZE-1:0] C_CAP_MAX    = '1;
    localparam logic [COUNTSIZE-1:0] C_CAP_ONE    = COUNTSIZE'(1);

    logic [2:0]           state_q, state_d;
    logic [15:0]          tmr_q, tmr_d;
    logic [COUNTSIZE-1:0] n_q, n_d;
    logic [COUNTSIZE-1:0] cap_q, cap_d;
    logic [15:0]          drop_q, drop_d;
    logic                 ovf_q, ovf_d;
    logic                 wren_q, wren_d;
    logic [DATASIZE-1:0]  din_q, din_d;
    logic                 pipe_q, pipe_d;

    logic                 w_go;
    logic                 w_room;
    logic [COUNTSIZE-1:0] w_cap_inc;

    // stop dominates a coincident start
    assign w_go      = g_start & ~g_stop;
    assign w_room    = ({1'b0, g_wr_count} < C_ROOM_LIMIT);
    assign w_cap_inc = cap_q + C_CAP_ONE;

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        n_d     = n_q;
        cap_d   = cap_q;
        drop_d  = drop_q;
        ovf_d   = ovf_q;
        wren_d  = 1'b0;
        din_d   = din_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (w_go) begin
                    state_d = S_FLUSH;
                    tmr_d   = '0;
                    n_d     = g_n_samples;
                    cap_d   = '0;
                    drop_d  = '0;
                    ovf_d   = 1'b0;
                end
            end
            S_FLUSH: begin
                if (g_stop) begin
                    state_d = S_IDLE;
                end else if (tmr_q == C_FLUSH_LAST) begin
                    state_d = S_SETTLE;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + 16'd1;
                end
            end
            S_SETTLE: begin
                if (g_stop) begin
                    state_d = S_IDLE;
                end else if (tmr_q == C_SETTLE_LAST) begin
                    state_d = S_CAPTURE;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + 16'd1;
                end
            end
            S_CAPTURE: begin
                if (g_stop) begin
                    state_d = S_DONE;
                end else if (g_valid) begin
                    if (w_room) begin
                        wren_d = 1'b1;
                        din_d  = g_din;
                        if (cap_q != C_CAP_MAX) begin
                            cap_d = w_cap_inc;
                        end
                        if ((n_q != '0) && (w_cap_inc == n_q)) begin
                            state_d = S_DONE;
                        end
                    end else begin
                        if (drop_q != 16'hFFFF) begin
                            drop_d = drop_q + 16'd1;
                        end
                        ovf_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // gated on the upcoming state so ready drops as soon as FLUSH begins
        pipe_d = ({1'b0, g_rd_count} >= C_BLOCK_LIM) &&
                 ((state_d == S_CAPTURE) || (state_d == S_DONE));
    end

    always_ff @(posedge g_clk) begin
        if (g_rst) begin
            state_q <= S_IDLE;
            tmr_q   <= '0;
            n_q     <= '0;
            cap_q   <= '0;
            drop_q  <= '0;
            ovf_q   <= 1'b0;
            wren_q  <= 1'b0;
            din_q   <= '0;
            pipe_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            n_q     <= n_d;
            cap_q   <= cap_d;
            drop_q  <= drop_d;
            ovf_q   <= ovf_d;
            wren_q  <= wren_d;
            din_q   <= din_d;
            pipe_q  <= pipe_d;
        end
    end

    assign g_fifo_srst  = (state_q == S_FLUSH);
    assign g_done       = (state_q == S_DONE);
    assign g_state      = state_q;
    assign g_fifo_wren  = wren_q;
    assign g_fifo_din   = din_q;
    assign g_pipe_ready = pipe_q;
    assign g_captured   = cap_q;
    assign g_dropped    = drop_q;
    assign g_overflow   = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_acq_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_acq_fifo_ctrl
// Purpose  : Scoreboard bench for acq_fifo_ctrl with a timeline-based model.
// Revision : 1.0  initial release
// ============================================================================
module tb_acq_fifo_ctrl;

    localparam int RST_C    = 4;
    localparam int SETTLE_C = 30;
    localparam int LIMIT    = 131072 - 128;
    localparam int BLOCK    = 256;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [31:0] nsamp = '0;
    logic        valid = 1'b0;
    logic [7:0]  din = '0;
    logic [17:0] wr = '0;
    logic [15:0] rd = '0;

    wire         srst, wren, pready, done, ovf;
    wire  [7:0]  fdin;
    wire  [2:0]  st;
    wire  [31:0] cap;
    wire  [15:0] drop;

    always #5 clk = ~clk;

    acq_fifo_ctrl dut (
        .g_clk(clk), .g_rst(rst), .g_start(start), .g_stop(stop),
        .g_n_samples(nsamp), .g_valid(valid), .g_din(din),
        .g_wr_count(wr), .g_rd_count(rd),
        .g_fifo_srst(srst), .g_fifo_wren(wren), .g_fifo_din(fdin),
        .g_pipe_ready(pready), .g_state(st), .g_captured(cap),
        .g_dropped(drop), .g_overflow(ovf), .g_done(done)
    );

    typedef struct {
        int         due;
        logic [7:0] d;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   ecnt  = 0;

    // model: phase derived from elapsed time since the accepted start
    int          m_st = 0;
    int          m_t0 = 0;
    logic [31:0] m_n = '0;
    logic [31:0] m_cap = '0;
    int          m_drop = 0;
    bit          m_ovf = 1'b0;
    bit          m_pipe = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (edge %0d)", nm, act, exp, ecnt);
        end
    endtask

    task automatic model_edge();
        int ns;
        int e;
        ns = m_st;
        if (rst) begin
            m_st = 0; m_n = '0; m_cap = '0; m_drop = 0; m_ovf = 1'b0; m_pipe = 1'b0;
            return;
        end
        case (m_st)
            0, 4: if (start && !stop) begin
                ns = 1; m_t0 = ecnt; m_n = nsamp; m_cap = '0; m_drop = 0; m_ovf = 1'b0;
            end
            1, 2: if (stop) ns = 0;
                  else begin
                      e  = ecnt + 1 - m_t0;
                      ns = (e <= RST_C) ? 1 : (e <= RST_C + SETTLE_C) ? 2 : 3;
                  end
            3: if (stop) ns = 4;
               else if (valid) begin
                   if (int'(wr) < LIMIT) begin
                       exp_q.push_back('{due: ecnt, d: din});
                       if (m_cap != 32'hFFFF_FFFF) m_cap = m_cap + 1;
                       if (m_n != 0 && m_cap == m_n) ns = 4;
                   end else begin
                       if (m_drop != 65535) m_drop++;
                       m_ovf = 1'b1;
                   end
               end
            default: ns = 0;
        endcase
        m_pipe = (int'(rd) >= BLOCK) && (ns == 3 || ns == 4);
        m_st   = ns;
    endtask

    task automatic step();
        bit was_rst;
        @(posedge clk);
        ecnt++;
        was_rst = rst;
        model_edge();
        #1;
        chk("state",    st,     m_st);
        chk("srst",     srst,   m_st == 1);
        chk("done",     done,   m_st == 4);
        chk("captured", cap,    m_cap);
        chk("dropped",  drop,   m_drop);
        chk("overflow", ovf,    m_ovf);
        chk("pipe_rdy", pready, m_pipe);
        if (was_rst) begin
            chk("rst_wren", wren, 0);
            chk("rst_din",  fdin, 0);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            din = 8'($urandom);
            step();
        end
    endtask

    task automatic pulse(input bit s, input bit p);
        start = s; stop = p;
        step();
        start = 1'b0; stop = 1'b0;
    endtask

    // write-port monitor: every wren must match the oldest outstanding accept
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (wren === 1'b1) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL wren_unexpected: got wren=1 din=%0d want no write (edge %0d)", fdin, ecnt);
                end else begin
                    e = exp_q.pop_front();
                    if (e.d !== fdin || e.due != ecnt) begin
                        bad++;
                        $display("FAIL wr_data: got din=%0d at edge %0d want din=%0d at edge %0d",
                                 fdin, ecnt, e.d, e.due);
                    end
                end
            end else if (exp_q.size() > 0 && exp_q[0].due <= ecnt) begin
                total++;
                bad++;
                $display("FAIL wren_missing: got wren=%b want write of %0d (edge %0d)", wren, exp_q[0].d, ecnt);
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        run(3);
        rst = 1'b0;
        run(2);

        // basic N=10 capture with valid every cycle
        nsamp = 32'd10; valid = 1'b1;
        pulse(1'b1, 1'b0);
        run(60);

        // stop in SETTLE -> IDLE, no writes
        nsamp = 32'd0;
        pulse(1'b1, 1'b0);
        run(10);
        pulse(1'b0, 1'b1);
        run(5);

        // unbounded capture: overflow, recovery, pipe ready edge, stop
        valid = 1'b0; rd = 16'd255;
        pulse(1'b1, 1'b0);
        run(36);
        wr = 18'd130944; valid = 1'b1;
        run(5);
        wr = 18'd100;
        run(4);
        rd = 16'd256;
        run(3);
        pulse(1'b0, 1'b1);
        run(4);
        pulse(1'b1, 1'b1);
        run(3);

        // restart from DONE with ready asserted: ready low through FLUSH/SETTLE
        rd = 16'd300;
        pulse(1'b1, 1'b0);
        run(40);
        pulse(1'b0, 1'b1);

        // reset mid capture after 3 accepts with N=8
        valid = 1'b0; nsamp = 32'd8;
        pulse(1'b1, 1'b0);
        run(34);
        valid = 1'b1;
        run(3);
        rst = 1'b1;
        run(2);
        rst = 1'b0;
        run(5);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            rst   = ($urandom_range(0, 699) == 0);
            start = ($urandom_range(0, 59) == 0);
            stop  = ($urandom_range(0, 89) == 0);
            valid = $urandom_range(0, 1) == 1;
            case ($urandom_range(0, 3))
                0: wr = 18'($urandom_range(0, LIMIT - 1));
                1: wr = 18'(LIMIT - 1);
                2: wr = 18'(LIMIT);
                default: wr = 18'($urandom_range(LIMIT, 262143));
            endcase
            rd = 16'($urandom_range(250, 262));
            if (start) nsamp = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 25));
            run(1);
        end
        rst = 1'b0; start = 1'b0; stop = 1'b0; valid = 1'b0;
        run(5);
        chk("pending_writes", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
